// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the PWM motor driver family.
//   - Default counter and dead-time widths.
//   - Encoding of the dead-time state machine (OFF, HI, LO, DEAD).
//   - mag_shift_clamp(): turns a signed controller command into an unsigned
//     duty. It saturates the magnitude, scales it with a right shift, and
//     limits it to a ceiling.
package pwm_pkg;

    localparam int CNT_W_DEFAULT  = 10;
    localparam int DEAD_W_DEFAULT = 4;

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_HI   = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;
    localparam logic [1:0] ST_DEAD = 2'd3;

    // -32768 has no positive counterpart in 16 bits. It saturates to 32767 so
    // the full-scale negative command keeps the same magnitude as the
    // full-scale positive one.
    function automatic logic [15:0] mag_shift_clamp(
        input logic signed [15:0] value,
        input logic [3:0]         shift,
        input logic [15:0]        limit
    );
        logic [15:0] mag;
        if (value == 16'sh8000) begin
            mag = 16'h7FFF;
        end else if (value[15]) begin
            mag = 16'(-value);
        end else begin
            mag = value;
        end
        mag = mag >> shift;
        if (mag > limit) begin
            mag = limit;
        end
        return mag;
    endfunction

endpackage

// File: rtl/dead_time_gen.sv
// dead_time_gen
// Break-before-make generator for a complementary half-bridge gate pair.
// It is driven with the values the top will hold in the NEXT cycle. The
// registered gates therefore line up with the period counter that runs in the
// same cycle.
// Ports:
//   clk_in_i   system clock
//   reset_n_i  synchronous active-low reset
//   raw        requested side for next cycle (1 = high side, 0 = low side)
//   dir_act    direction for next cycle; a change forces a dead gap
//   dead_act   dead time in clocks for next cycle (0 = switch directly)
//   run        counter running next cycle; low forces both gates off
//   pwm_hi     high-side gate (registered)
//   pwm_lo     low-side gate (registered)
module dead_time_gen
    import pwm_pkg::*;
#(
    parameter int DEAD_W = DEAD_W_DEFAULT
) (
    input  logic              clk_in_i,
    input  logic              reset_n_i,
    input  logic              raw,
    input  logic              dir_act,
    input  logic [DEAD_W-1:0] dead_act,
    input  logic              run,
    output logic              pwm_hi,
    output logic              pwm_lo
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DEAD_W-1:0] dead_cnt;
    logic [DEAD_W-1:0] dead_cnt_nxt;
    logic              dir_q;
    logic              dir_flip;
    logic [1:0]        side;

    assign side     = raw ? ST_HI : ST_LO;
    assign dir_flip = (dir_act != dir_q);

    // Next-state logic. Any swap away from a driven side first passes through
    // DEAD, with both gates low for dead_act cycles. The side chosen on leaving
    // DEAD is taken from the current raw request and not from a stored target.
    // A duty edge that lands inside the gap is then still honoured, and the gap
    // never gets shorter.
    always_comb begin
        state_nxt    = state;
        dead_cnt_nxt = dead_cnt;
        if (!run) begin
            state_nxt    = ST_OFF;
            dead_cnt_nxt = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (dead_act == '0) begin
                        state_nxt = side;
                    end else begin
                        state_nxt    = ST_DEAD;
                        dead_cnt_nxt = dead_act - DEAD_W'(1);
                    end
                end
                ST_HI: begin
                    if (!raw || dir_flip) begin
                        if (dead_act == '0) begin
                            state_nxt = side;
                        end else begin
                            state_nxt    = ST_DEAD;
                            dead_cnt_nxt = dead_act - DEAD_W'(1);
                        end
                    end
                end
                ST_LO: begin
                    if (raw || dir_flip) begin
                        if (dead_act == '0) begin
                            state_nxt = side;
                        end else begin
                            state_nxt    = ST_DEAD;
                            dead_cnt_nxt = dead_act - DEAD_W'(1);
                        end
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt == '0) begin
                        state_nxt = side;
                    end else begin
                        dead_cnt_nxt = dead_cnt - DEAD_W'(1);
                    end
                end
                default: begin
                    state_nxt    = ST_OFF;
                    dead_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State, dead counter and the gate flops. Each gate is decoded from a
    // single state value, so both gates can never be high together.
    always_ff @(posedge clk_in_i) begin
        if (!reset_n_i) begin
            state    <= ST_OFF;
            dead_cnt <= '0;
            dir_q    <= 1'b0;
            pwm_hi   <= 1'b0;
            pwm_lo   <= 1'b0;
        end else begin
            state    <= state_nxt;
            dead_cnt <= dead_cnt_nxt;
            dir_q    <= dir_act;
            pwm_hi   <= (state_nxt == ST_HI);
            pwm_lo   <= (state_nxt == ST_LO);
        end
    end

endmodule

// File: rtl/pwm_driver.sv
// pwm_driver
// Converts the signed PID output into a complementary half-bridge PWM pair
// with a direction flag. Commands are captured into a pending buffer and
// become active only at period boundaries. Dead-time insertion is done in
// dead_time_gen.
// Ports:
//   clk_in_i        system clock
//   reset_n_i       synchronous active-low reset
//   en_i            run enable; low forces both gates off and holds counter at 0
//   pid_i           signed controller output
//   pid_valid_i     one-cycle strobe qualifying pid_i
//   shift_i         right shift applied to |pid_i|
//   period_i        PWM period in clocks, sampled at period boundary
//   dead_i          dead time in clocks, sampled at period boundary
//   pwm_hi_o        high-side gate
//   pwm_lo_o        low-side gate
//   dir_o           active direction (1 = negative command)
//   duty_o          active duty in clocks
//   period_start_o  high while the period counter is 0
module pwm_driver
    import pwm_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int DEAD_W = DEAD_W_DEFAULT
) (
    input  logic               clk_in_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic signed [15:0] pid_i,
    input  logic               pid_valid_i,
    input  logic [3:0]         shift_i,
    input  logic [CNT_W-1:0]   period_i,
    input  logic [DEAD_W-1:0]  dead_i,
    output logic               pwm_hi_o,
    output logic               pwm_lo_o,
    output logic               dir_o,
    output logic [CNT_W-1:0]   duty_o,
    output logic               period_start_o
);

    logic [CNT_W-1:0]  pending_duty;
    logic              pending_dir;

    logic              running;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period_act;
    logic [CNT_W-1:0]  duty_act;
    logic              dir_act;
    logic [DEAD_W-1:0] dead_act;
    logic              period_start;

    logic              run_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  period_nxt;
    logic [CNT_W-1:0]  duty_nxt;
    logic              dir_nxt;
    logic [DEAD_W-1:0] dead_nxt;
    logic              start_nxt;
    logic              raw_nxt;

    logic              wrap;
    logic              load;

    assign wrap = running && (cnt == period_act - CNT_W'(1));
    assign load = en_i && (!running || wrap);

    // Pending command buffer. It captures on every strobe, even while
    // disabled, and a newer strobe simply overwrites an older one. The clamp
    // uses the period currently on the input. The period that later becomes
    // active may differ; if it is shorter, the duty saturates to full-on.
    always_ff @(posedge clk_in_i) begin
        if (!reset_n_i) begin
            pending_duty <= '0;
            pending_dir  <= 1'b0;
        end else if (pid_valid_i) begin
            pending_duty <= CNT_W'(mag_shift_clamp(pid_i, shift_i, 16'(period_i)));
            pending_dir  <= pid_i[15];
        end
    end

    // Next-cycle view of the counter and active registers. A load happens on
    // the first enabled cycle while idle and again at every wrap. It reads the
    // pending registers before this edge updates them, so a strobe that
    // arrives together with a wrap waits for the following wrap. A zero
    // period keeps the driver idle, and the next enabled cycle samples the
    // period again.
    always_comb begin
        run_nxt    = running;
        cnt_nxt    = cnt + CNT_W'(1);
        period_nxt = period_act;
        duty_nxt   = duty_act;
        dir_nxt    = dir_act;
        dead_nxt   = dead_act;
        start_nxt  = 1'b0;
        if (!en_i) begin
            run_nxt = 1'b0;
            cnt_nxt = '0;
        end else if (load) begin
            cnt_nxt = '0;
            if (period_i != '0) begin
                run_nxt    = 1'b1;
                period_nxt = period_i;
                duty_nxt   = pending_duty;
                dir_nxt    = pending_dir;
                dead_nxt   = dead_i;
                start_nxt  = 1'b1;
            end else begin
                run_nxt = 1'b0;
            end
        end
    end

    // The raw request is formed from next-cycle values. The gate flops in
    // dead_time_gen then switch on the same edge at which the counter crosses
    // the duty.
    assign raw_nxt = (cnt_nxt < duty_nxt);

    // Period counter and active (double-buffered) registers.
    always_ff @(posedge clk_in_i) begin
        if (!reset_n_i) begin
            running      <= 1'b0;
            cnt          <= '0;
            period_act   <= '0;
            duty_act     <= '0;
            dir_act      <= 1'b0;
            dead_act     <= '0;
            period_start <= 1'b0;
        end else begin
            running      <= run_nxt;
            cnt          <= cnt_nxt;
            period_act   <= period_nxt;
            duty_act     <= duty_nxt;
            dir_act      <= dir_nxt;
            dead_act     <= dead_nxt;
            period_start <= start_nxt;
        end
    end

    dead_time_gen #(
        .DEAD_W (DEAD_W)
    ) u_dead_time_gen (
        .clk_in_i  (clk_in_i),
        .reset_n_i (reset_n_i),
        .raw       (raw_nxt),
        .dir_act   (dir_nxt),
        .dead_act  (dead_nxt),
        .run       (run_nxt),
        .pwm_hi    (pwm_hi_o),
        .pwm_lo    (pwm_lo_o)
    );

    assign dir_o          = dir_act;
    assign duty_o         = duty_act;
    assign period_start_o = period_start;

endmodule

// File: tb/tb_pwm_driver.sv
// tb_pwm_driver
// Directed checks of pwm_driver: reset state, duty generation, saturation,
// dead-time gaps, wrap/strobe collision, enable, zero period, mid-period reset,
// and a random overlap soak.
module tb_pwm_driver;

    logic               clk_in_i;
    logic               reset_n_i;
    logic               en_i;
    logic signed [15:0] pid_i;
    logic               pid_valid_i;
    logic [3:0]         shift_i;
    logic [9:0]         period_i;
    logic [3:0]         dead_i;
    logic               pwm_hi_o;
    logic               pwm_lo_o;
    logic               dir_o;
    logic [9:0]         duty_o;
    logic               period_start_o;

    int compared;
    int mismatched;

    pwm_driver #(
        .CNT_W  (10),
        .DEAD_W (4)
    ) dut (
        .clk_in_i       (clk_in_i),
        .reset_n_i      (reset_n_i),
        .en_i           (en_i),
        .pid_i          (pid_i),
        .pid_valid_i    (pid_valid_i),
        .shift_i        (shift_i),
        .period_i       (period_i),
        .dead_i         (dead_i),
        .pwm_hi_o       (pwm_hi_o),
        .pwm_lo_o       (pwm_lo_o),
        .dir_o          (dir_o),
        .duty_o         (duty_o),
        .period_start_o (period_start_o)
    );

    // Free-running 10-unit clock. The bench drives inputs and samples outputs
    // on the falling edge, away from the active edge.
    initial clk_in_i = 1'b0;
    always #5 clk_in_i = ~clk_in_i;

    // Puts the DUT into a clean idle state. The task returns on a falling edge
    // with reset released and enable low.
    task automatic do_reset();
        reset_n_i   = 1'b0;
        en_i        = 1'b0;
        pid_valid_i = 1'b0;
        pid_i       = '0;
        @(negedge clk_in_i);
        @(negedge clk_in_i);
        reset_n_i = 1'b1;
        @(negedge clk_in_i);
    endtask

    // Issues a one-cycle command strobe.
    task automatic strobe(input logic signed [15:0] value);
        pid_i       = value;
        pid_valid_i = 1'b1;
        @(negedge clk_in_i);
        pid_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i   = 1'b0;
        en_i        = 1'b0;
        pid_valid_i = 1'b0;
        pid_i       = '0;
        shift_i     = '0;
        period_i    = 10'd1000;
        dead_i      = '0;
        repeat (3) @(negedge clk_in_i);
        compared++;
        if (pwm_hi_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_hi: got %b expected 0", pwm_hi_o);
        end
        compared++;
        if (pwm_lo_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_lo: got %b expected 0", pwm_lo_o);
        end
        compared++;
        if (dir_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_dir: got %b expected 0", dir_o);
        end
        compared++;
        if (duty_o !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_duty: got %0d expected 0", duty_o);
        end
        compared++;
        if (period_start_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_start: got %b expected 0", period_start_o);
        end
        reset_n_i = 1'b1;
        @(negedge clk_in_i);
        compared++;
        if ({pwm_hi_o, pwm_lo_o, period_start_o} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL idle_after_reset: got %b expected 000",
                     {pwm_hi_o, pwm_lo_o, period_start_o});
        end
    endtask

    task automatic test_basic_duty();
        int hi_cnt;
        int lo_cnt;
        int start_cnt;
        hi_cnt    = 0;
        lo_cnt    = 0;
        start_cnt = 0;
        do_reset();
        period_i = 10'd1000;
        dead_i   = 4'd0;
        shift_i  = 4'd0;
        strobe(16'sd300);
        en_i = 1'b1;
        @(negedge clk_in_i);
        compared++;
        if (period_start_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL basic_start: got %b expected 1", period_start_o);
        end
        compared++;
        if (duty_o !== 10'd300) begin
            mismatched++;
            $display("[TB] FAIL basic_duty: got %0d expected 300", duty_o);
        end
        compared++;
        if (dir_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_dir: got %b expected 0", dir_o);
        end
        for (int i = 0; i < 1000; i++) begin
            if (pwm_hi_o === 1'b1) hi_cnt++;
            if (pwm_lo_o === 1'b1) lo_cnt++;
            if (period_start_o === 1'b1) start_cnt++;
            @(negedge clk_in_i);
        end
        compared++;
        if (hi_cnt != 300) begin
            mismatched++;
            $display("[TB] FAIL basic_hi_cycles: got %0d expected 300", hi_cnt);
        end
        compared++;
        if (lo_cnt != 700) begin
            mismatched++;
            $display("[TB] FAIL basic_lo_cycles: got %0d expected 700", lo_cnt);
        end
        compared++;
        if (start_cnt != 1) begin
            mismatched++;
            $display("[TB] FAIL basic_start_count: got %0d expected 1", start_cnt);
        end
        compared++;
        if (period_start_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL basic_wrap_start: got %b expected 1", period_start_o);
        end
        en_i = 1'b0;
    endtask

    task automatic test_neg_saturate();
        int hi_cnt;
        int lo_cnt;
        hi_cnt = 0;
        lo_cnt = 0;
        do_reset();
        period_i = 10'd1000;
        dead_i   = 4'd0;
        shift_i  = 4'd4;
        strobe(16'sh8000);
        en_i = 1'b1;
        @(negedge clk_in_i);
        compared++;
        if (duty_o !== 10'd1000) begin
            mismatched++;
            $display("[TB] FAIL sat_duty: got %0d expected 1000", duty_o);
        end
        compared++;
        if (dir_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sat_dir: got %b expected 1", dir_o);
        end
        for (int i = 0; i < 1000; i++) begin
            if (pwm_hi_o === 1'b1) hi_cnt++;
            if (pwm_lo_o === 1'b1) lo_cnt++;
            @(negedge clk_in_i);
        end
        compared++;
        if (hi_cnt != 1000) begin
            mismatched++;
            $display("[TB] FAIL sat_hi_cycles: got %0d expected 1000", hi_cnt);
        end
        compared++;
        if (lo_cnt != 0) begin
            mismatched++;
            $display("[TB] FAIL sat_lo_cycles: got %0d expected 0", lo_cnt);
        end
        en_i    = 1'b0;
        shift_i = 4'd0;
    endtask

    task automatic test_dead_time();
        int hi_cnt;
        int lo_cnt;
        int off_cnt;
        int overlap;
        int first_hi;
        int first_lo;
        int second_hi;
        hi_cnt    = 0;
        lo_cnt    = 0;
        off_cnt   = 0;
        overlap   = 0;
        first_hi  = -1;
        first_lo  = -1;
        second_hi = -1;
        do_reset();
        period_i = 10'd1000;
        dead_i   = 4'd3;
        shift_i  = 4'd0;
        strobe(16'sd500);
        en_i = 1'b1;
        @(negedge clk_in_i);
        for (int i = 0; i < 2000; i++) begin
            if (pwm_hi_o === 1'b1 && pwm_lo_o === 1'b1) overlap++;
            if (pwm_hi_o === 1'b1) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
                if (second_hi < 0 && i >= 1000) second_hi = i;
            end
            if (pwm_lo_o === 1'b1) begin
                lo_cnt++;
                if (first_lo < 0) first_lo = i;
            end
            if (pwm_hi_o === 1'b0 && pwm_lo_o === 1'b0) off_cnt++;
            @(negedge clk_in_i);
        end
        compared++;
        if (first_hi != 3) begin
            mismatched++;
            $display("[TB] FAIL dead_first_hi: got %0d expected 3", first_hi);
        end
        compared++;
        if (first_lo != 503) begin
            mismatched++;
            $display("[TB] FAIL dead_first_lo: got %0d expected 503", first_lo);
        end
        compared++;
        if (second_hi != 1003) begin
            mismatched++;
            $display("[TB] FAIL dead_second_hi: got %0d expected 1003", second_hi);
        end
        compared++;
        if (off_cnt != 12) begin
            mismatched++;
            $display("[TB] FAIL dead_gap_cycles: got %0d expected 12", off_cnt);
        end
        compared++;
        if (hi_cnt != 994 || lo_cnt != 994) begin
            mismatched++;
            $display("[TB] FAIL dead_side_cycles: got hi=%0d lo=%0d expected 994/994",
                     hi_cnt, lo_cnt);
        end
        compared++;
        if (overlap != 0) begin
            mismatched++;
            $display("[TB] FAIL dead_overlap: got %0d expected 0", overlap);
        end
        en_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int hi_cnt;
        hi_cnt = 0;
        do_reset();
        period_i = 10'd1000;
        dead_i   = 4'd0;
        shift_i  = 4'd0;
        strobe(16'sd100);
        en_i = 1'b1;
        @(negedge clk_in_i);
        repeat (999) @(negedge clk_in_i);
        pid_i       = 16'sd200;
        pid_valid_i = 1'b1;
        @(negedge clk_in_i);
        pid_valid_i = 1'b0;
        compared++;
        if (period_start_o !== 1'b1 || duty_o !== 10'd100) begin
            mismatched++;
            $display("[TB] FAIL collide_old_duty: got start=%b duty=%0d expected 1/100",
                     period_start_o, duty_o);
        end
        for (int i = 0; i < 1000; i++) begin
            if (pwm_hi_o === 1'b1) hi_cnt++;
            @(negedge clk_in_i);
        end
        compared++;
        if (hi_cnt != 100) begin
            mismatched++;
            $display("[TB] FAIL collide_hi_cycles: got %0d expected 100", hi_cnt);
        end
        compared++;
        if (period_start_o !== 1'b1 || duty_o !== 10'd200) begin
            mismatched++;
            $display("[TB] FAIL collide_new_duty: got start=%b duty=%0d expected 1/200",
                     period_start_o, duty_o);
        end
        en_i = 1'b0;
    endtask

    task automatic test_enable();
        int hi_cnt;
        hi_cnt = 0;
        do_reset();
        period_i = 10'd1000;
        dead_i   = 4'd0;
        shift_i  = 4'd0;
        strobe(16'sd400);
        en_i = 1'b1;
        @(negedge clk_in_i);
        repeat (50) @(negedge clk_in_i);
        en_i = 1'b0;
        @(negedge clk_in_i);
        compared++;
        if (pwm_hi_o !== 1'b0 || pwm_lo_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL en_off_gates: got hi=%b lo=%b expected 0/0",
                     pwm_hi_o, pwm_lo_o);
        end
        compared++;
        if (dut.cnt !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL en_off_cnt: got %0d expected 0", dut.cnt);
        end
        repeat (3) @(negedge clk_in_i);
        en_i = 1'b1;
        @(negedge clk_in_i);
        compared++;
        if (period_start_o !== 1'b1 || pwm_hi_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL en_restart: got start=%b hi=%b expected 1/1",
                     period_start_o, pwm_hi_o);
        end
        for (int i = 0; i < 1000; i++) begin
            if (pwm_hi_o === 1'b1) hi_cnt++;
            @(negedge clk_in_i);
        end
        compared++;
        if (hi_cnt != 400) begin
            mismatched++;
            $display("[TB] FAIL en_full_period: got %0d expected 400", hi_cnt);
        end
        en_i = 1'b0;
    endtask

    task automatic test_zero_period();
        int active;
        active = 0;
        do_reset();
        period_i = 10'd1000;
        dead_i   = 4'd0;
        shift_i  = 4'd0;
        strobe(16'sd50);
        period_i = 10'd0;
        en_i     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in_i);
            if (period_start_o !== 1'b0 || pwm_hi_o !== 1'b0 || pwm_lo_o !== 1'b0) active++;
        end
        compared++;
        if (active != 0) begin
            mismatched++;
            $display("[TB] FAIL zero_period_idle: got %0d active cycles expected 0", active);
        end
        period_i = 10'd1000;
        @(negedge clk_in_i);
        compared++;
        if (period_start_o !== 1'b1 || duty_o !== 10'd50 || pwm_hi_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL zero_period_resume: got start=%b duty=%0d hi=%b expected 1/50/1",
                     period_start_o, duty_o, pwm_hi_o);
        end
        en_i = 1'b0;
    endtask

    task automatic test_midperiod_reset();
        do_reset();
        period_i = 10'd1000;
        dead_i   = 4'd0;
        shift_i  = 4'd0;
        strobe(-16'sd400);
        en_i = 1'b1;
        @(negedge clk_in_i);
        repeat (100) @(negedge clk_in_i);
        compared++;
        if (pwm_hi_o !== 1'b1 || dir_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rst_pre_state: got hi=%b dir=%b expected 1/1", pwm_hi_o, dir_o);
        end
        reset_n_i = 1'b0;
        @(negedge clk_in_i);
        compared++;
        if ({pwm_hi_o, pwm_lo_o, dir_o, period_start_o} !== 4'b0000 || duty_o !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL rst_outputs: got hi=%b lo=%b dir=%b start=%b duty=%0d expected all 0",
                     pwm_hi_o, pwm_lo_o, dir_o, period_start_o, duty_o);
        end
        reset_n_i = 1'b1;
        @(negedge clk_in_i);
        compared++;
        if (period_start_o !== 1'b1 || duty_o !== 10'd0 || pwm_lo_o !== 1'b1 || pwm_hi_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_pending_cleared: got start=%b duty=%0d hi=%b lo=%b expected 1/0/0/1",
                     period_start_o, duty_o, pwm_hi_o, pwm_lo_o);
        end
        en_i = 1'b0;
    endtask

    task automatic test_random_overlap();
        int overlap;
        overlap = 0;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk_in_i);
            if (pwm_hi_o === 1'b1 && pwm_lo_o === 1'b1) overlap++;
            en_i        = ($urandom_range(0, 19) != 0);
            pid_i       = 16'($urandom);
            pid_valid_i = ($urandom_range(0, 3) == 0);
            shift_i     = 4'($urandom_range(0, 15));
            dead_i      = 4'($urandom_range(0, 15));
            period_i    = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 40));
        end
        pid_valid_i = 1'b0;
        en_i        = 1'b0;
        compared++;
        if (overlap != 0) begin
            mismatched++;
            $display("[TB] FAIL random_overlap: got %0d cycles expected 0", overlap);
        end
    endtask

    // Runs every scenario in order and prints the single summary line.
    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_basic_duty();
        test_neg_saturate();
        test_dead_time();
        test_back_to_back();
        test_enable();
        test_zero_period();
        test_midperiod_reset();
        test_random_overlap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pwm_driver.md
# pwm_driver

Consumes the signed PID output and turns it into a complementary half-bridge PWM pair with a direction flag. Magnitude is scaled and clamped to the PWM period, duty and direction are double-buffered and applied only at period boundaries, and a dead-time generator guarantees a break-before-make gap on every high/low swap. Sits directly downstream of the PID controller, in the same clock domain, strobed by the controller's slow enable.

## Interface

Parameters:
- CNT_W, 10: period counter and duty width.
- DEAD_W, 4: dead-time counter width.

Ports:
- clk_in_i  in  1  system clock.
- reset_n_i  in  1  reset: synchronous, active-low.
- en_i  in  1  run enable; low forces outputs off.
- pid_i  in  16 (signed)  controller output, two's complement.
- pid_valid_i  in  1  one-cycle strobe; pid_i is valid in that cycle.
- shift_i  in  4  right-shift applied to |pid_i| before clamping.
- period_i  in  CNT_W  PWM period in clocks; sampled at period boundary.
- dead_i  in  DEAD_W  dead time in clocks; sampled at period boundary.
- pwm_hi_o  out  1  high-side gate.
- pwm_lo_o  out  1  low-side gate.
- dir_o  out  1  sign of active command (1 = negative).
- duty_o  out  CNT_W  active duty in clocks.
- period_start_o  out  1  high during the cycle the counter is 0.

## Operation

- Capture: on pid_valid_i, mag = |pid_i| (−32768 saturates to 32767), mag >>= shift_i, clamp to period_i (current input value); write pending duty and pending dir = pid_i[15]. Later strobes overwrite pending; no queueing.
- Counter: cnt runs 0 … period_act−1, then wraps to 0. At wrap (and at the first cycle after en_i rises), load duty_act/dir_act from pending, period_act from period_i, dead_act from dead_i.
- Raw drive: raw = (cnt < duty_act). duty 0 → low side all period; duty = period_act → high side all period.
- Dead-time FSM states: OFF, HI, LO, DEAD.
  - OFF: both gates low; entered on reset, en_i low, or period_act = 0. Leaves to DEAD (target from raw) when running.
  - HI: pwm_hi_o = 1. raw falls or dir_act changes at a boundary → DEAD (target LO/HI).
  - LO: pwm_lo_o = 1. raw rises or dir change → DEAD.
  - DEAD: both low for dead_act cycles, then target state. dead_act = 0 → skip DEAD (direct switch, never both high).
- pwm_hi_o and pwm_lo_o are never high in the same cycle, under any input.
- en_i low: counter held at 0, FSM to OFF, pending still captures. period_i = 0 sampled: treated as disabled until next nonzero sample (checked each cycle while in OFF).
- Simultaneous pid_valid_i and wrap: load uses pending value before the edge; the new strobe takes effect at the following wrap.
- Reset mid-period: all state cleared in one cycle, no partial period completes.

## Timing

- Reset values: pwm_hi_o 0, pwm_lo_o 0, dir_o 0, duty_o 0, period_start_o 0; cnt 0; pending 0; FSM OFF.
- All outputs registered.
- pid_valid_i at cycle t → pending at t+1 → active at next wrap; worst-case latency period_act+1 cycles.
- After en_i rises at t: period_start_o at t+1, first gate edge at t+1+dead_act.
- DEAD insertion delays each gate's rising edge by dead_act cycles; falling edges are immediate.
- dir_o and duty_o change only in the cycle period_start_o is high.

## Structure

- Shared package pwm_pkg: FSM state encoding, default CNT_W/DEAD_W, magnitude-saturate-shift-clamp function (reused by any future motor drivers).
- Sub-module dead_time_gen: FSM plus dead counter; inputs raw, dir_act, dead_act, run; outputs the two gates.
- Top: capture/clamp, pending and active registers, period counter.

## Test plan

- pid_i = 300, shift 0, period 1000, dead 0 → after wrap, pwm_hi_o high 300 cycles, low side 700, dir_o 0, duty_o 300.
- pid_i = −32768, shift 4, period 1000 → mag 2047 clamped to 1000, dir_o 1, hi side 100%, pwm_lo_o never high.
- dead 3, duty 500, period 1000 → both gates low exactly 3 cycles at each swap; assertion hi & lo never true across 10k random cycles.
- pid_valid_i in the exact wrap cycle with 200 (pending 100) → that period uses 100, next period uses 200.
- en_i low mid-period → next cycle both gates 0, cnt 0; en_i high → period_start_o one cycle later.
- reset_n_i low during HI state with duty 400 → next cycle all outputs at reset values; pending cleared (duty 0 after re-enable).
